// File: rtl/pmem_responder_if.sv
// Line-granular memory port between a cache (master) and pmem_responder (slave).
// Request is held by the master until the one-cycle resp pulse.
interface pmem_responder_if;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [255:0] wdata;
  logic         resp;
  logic [255:0] rdata;

  modport master (
    output read, write, address, wdata,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata,
    output resp, rdata
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency 256-bit line memory model answering cache read/write requests,
// with completion counters and a sticky protocol-violation flag.
module pmem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned LINES   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pmem_responder_if.slave  bus,
  output logic             proto_err,
  output logic [15:0]      read_cnt,
  output logic [15:0]      write_cnt
);

  localparam int unsigned IDX_W    = $clog2(LINES);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [255:0]       wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               perr_q, perr_d;
  logic [255:0]       rdata_q, rdata_d;
  logic [15:0]        read_cnt_q, read_cnt_d;
  logic [15:0]        write_cnt_q, write_cnt_d;
  logic [255:0]       mem_q [LINES];

  logic               req;
  logic [IDX_W-1:0]   idx_in;
  logic               cpl_en;
  logic               cpl_wr;
  logic [IDX_W-1:0]   cpl_idx;
  logic [255:0]       cpl_wdata;
  logic               unused_addr;

  assign req         = bus.read | bus.write;
  assign idx_in      = bus.address[5 +: IDX_W];
  assign unused_addr = ^{bus.address[31:5+IDX_W], bus.address[4:0]};

  // cpl_* describe the completion performed on the edge entering RESP; with
  // LATENCY=1 that edge is the acceptance edge, so it uses the live inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    perr_d    = perr_q;
    cpl_en    = 1'b0;
    cpl_wr    = wr_q;
    cpl_idx   = idx_q;
    cpl_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = idx_in;
          wdata_d = bus.wdata;
          wr_d    = bus.write;
          cnt_d   = CNT_LOAD;
          if (bus.read && bus.write) begin
            perr_d = 1'b1;
          end
          if (LATENCY == 1) begin
            state_d   = RESP;
            cpl_en    = 1'b1;
            cpl_wr    = bus.write;
            cpl_idx   = idx_in;
            cpl_wdata = bus.wdata;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (!req) begin
          perr_d = 1'b1;
        end
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cpl_en  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_d     = rdata_q;
    read_cnt_d  = read_cnt_q;
    write_cnt_d = write_cnt_q;
    if (cpl_en) begin
      if (cpl_wr) begin
        write_cnt_d = write_cnt_q + 16'd1;
      end else begin
        rdata_d    = mem_q[cpl_idx];
        read_cnt_d = read_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      perr_q      <= 1'b0;
      rdata_q     <= '0;
      read_cnt_q  <= '0;
      write_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      perr_q      <= perr_d;
      rdata_q     <= rdata_d;
      read_cnt_q  <= read_cnt_d;
      write_cnt_q <= write_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (cpl_en && cpl_wr) begin
      mem_q[cpl_idx] <= cpl_wdata;
    end
  end

  assign bus.resp  = (state_q == RESP);
  assign bus.rdata = rdata_q;
  assign proto_err = perr_q;
  assign read_cnt  = read_cnt_q;
  assign write_cnt = write_cnt_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized bench for pmem_responder: two instances (LATENCY 4 / 16 lines and
// LATENCY 1 / 8 lines) checked against a transaction-level memory model.
module tb_pmem_responder;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         rd   [2];
  logic         wr   [2];
  logic [31:0]  ad   [2];
  logic [255:0] wd   [2];
  logic         rstn [2];
  logic         rsp  [2];
  logic [255:0] rdt  [2];
  logic         perr [2];
  logic [15:0]  rc   [2];
  logic [15:0]  wc   [2];

  logic         perr4, perr1;
  logic [15:0]  rc4, rc1, wc4, wc1;

  pmem_responder_if bus4();
  pmem_responder_if bus1();

  assign bus4.read    = rd[0];
  assign bus4.write   = wr[0];
  assign bus4.address = ad[0];
  assign bus4.wdata   = wd[0];
  assign bus1.read    = rd[1];
  assign bus1.write   = wr[1];
  assign bus1.address = ad[1];
  assign bus1.wdata   = wd[1];

  assign rsp[0]  = bus4.resp;
  assign rdt[0]  = bus4.rdata;
  assign rsp[1]  = bus1.resp;
  assign rdt[1]  = bus1.rdata;
  assign perr[0] = perr4;
  assign perr[1] = perr1;
  assign rc[0]   = rc4;
  assign rc[1]   = rc1;
  assign wc[0]   = wc4;
  assign wc[1]   = wc1;

  pmem_responder #(.LATENCY(4), .LINES(16)) u_l4 (
    .clk       (clk),
    .rst_n     (rstn[0]),
    .bus       (bus4),
    .proto_err (perr4),
    .read_cnt  (rc4),
    .write_cnt (wc4)
  );

  pmem_responder #(.LATENCY(1), .LINES(8)) u_l1 (
    .clk       (clk),
    .rst_n     (rstn[1]),
    .bus       (bus1),
    .proto_err (perr1),
    .read_cnt  (rc1),
    .write_cnt (wc1)
  );

  // Reference model: line array, counters, sticky error, last read line.
  int           lat_of   [2] = '{4, 1};
  int           lines_of [2] = '{16, 8};
  logic [255:0] m_mem    [2][64];
  logic [255:0] m_rdata  [2];
  int           m_rc     [2];
  int           m_wc     [2];
  bit           m_perr   [2];
  bit           after_resp [2];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic string tg(input int s, input string name);
    return $sformatf("L%0d_%s", lat_of[s], name);
  endfunction

  task automatic reset_model(input int s);
    for (int i = 0; i < 64; i++) m_mem[s][i] = '0;
    m_rdata[s] = '0;
    m_rc[s]    = 0;
    m_wc[s]    = 0;
    m_perr[s]  = 1'b0;
  endtask

  task automatic check_regs(input int s, input string what);
    check_eq(tg(s, {what, "_rdata"}), rdt[s], m_rdata[s]);
    check_eq(tg(s, {what, "_rcnt"}), 256'(rc[s]), 256'(m_rc[s]));
    check_eq(tg(s, {what, "_wcnt"}), 256'(wc[s]), 256'(m_wc[s]));
    check_eq(tg(s, {what, "_perr"}), 256'(perr[s]), 256'(m_perr[s]));
  endtask

  task automatic idle(input int s, input int k);
    repeat (k) @(negedge clk);
    if (k > 0) after_resp[s] = 1'b0;
  endtask

  // Called at a negedge while the instance is idle or in its resp cycle.
  task automatic txn(input int s, input bit r, input bit w, input logic [31:0] a,
                     input logic [255:0] d, input bit drop, input bit scr);
    int idx, n, exp_lat, first_busy;
    idx        = int'((a >> 5) & 32'(lines_of[s] - 1));
    exp_lat    = lat_of[s] + (after_resp[s] ? 1 : 0);
    first_busy = exp_lat - lat_of[s] + 1;
    rd[s] = r; wr[s] = w; ad[s] = a; wd[s] = d;
    if (w) begin
      m_mem[s][idx] = d;
      m_wc[s] = (m_wc[s] + 1) & 32'hFFFF;
    end else begin
      m_rdata[s] = m_mem[s][idx];
      m_rc[s] = (m_rc[s] + 1) & 32'hFFFF;
    end
    if (r && w) m_perr[s] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!rsp[s] && n >= first_busy && n < exp_lat) begin
        if (scr) begin
          ad[s] = $urandom;
          wd[s] = rand256();
        end
        if (drop && n == first_busy) begin
          rd[s] = 1'b0;
          wr[s] = 1'b0;
          m_perr[s] = 1'b1;
        end
      end
    end while (!rsp[s] && n < 40);
    check_eq(tg(s, "latency"), 256'(n), 256'(exp_lat));
    check_regs(s, "cpl");
    rd[s] = 1'b0;
    wr[s] = 1'b0;
    after_resp[s] = 1'b1;
  endtask

  task automatic random_phase(input int s, input int count);
    int sel;
    bit r, w;
    for (int t = 0; t < count; t++) begin
      sel = $urandom_range(0, 15);
      r = (sel < 7);
      w = (sel >= 7);
      if (sel == 15) r = 1'b1;
      txn(s, r, w, $urandom, rand256(), ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)));
      idle(s, $urandom_range(0, 2));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] a5, d1, d2, d3;
    int nresp;
    a5 = {32{8'hA5}};
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; ad[s] = '0; wd[s] = '0; rstn[s] = 1'b0;
      after_resp[s] = 1'b0;
      reset_model(s);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_eq(tg(s, "rst_resp"), 256'(rsp[s]), 256'(0));
      check_regs(s, "rst");
    end
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    // LATENCY=4 instance: first acceptance right after reset release
    txn(0, 1'b0, 1'b1, 32'h0000_0040, a5, 1'b0, 1'b0);
    idle(0, 1);
    txn(0, 1'b1, 1'b0, 32'h0000_0040, rand256(), 1'b0, 1'b1);
    idle(0, 1);
    txn(0, 1'b1, 1'b0, 32'h0000_0240, rand256(), 1'b0, 1'b0);
    idle(0, 1);

    // reset while BUSY with counter at 2 aborts the write to 0x80
    rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = 32'h0000_0080; wd[0] = rand256();
    repeat (2) @(negedge clk);
    rstn[0] = 1'b0;
    wr[0] = 1'b0;
    @(negedge clk);
    rstn[0] = 1'b1;
    reset_model(0);
    nresp = 0;
    repeat (6) begin
      if (rsp[0]) nresp++;
      @(negedge clk);
    end
    after_resp[0] = 1'b0;
    check_eq(tg(0, "abort_resp"), 256'(nresp), 256'(0));
    check_regs(0, "abort");
    txn(0, 1'b1, 1'b0, 32'h0000_0080, '0, 1'b0, 1'b0);
    idle(0, 1);
    txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);
    idle(0, 2);

    // request dropped mid-BUSY: error flagged, write still lands
    d3 = rand256();
    txn(0, 1'b0, 1'b1, 32'h0000_0100, d3, 1'b1, 1'b0);
    idle(0, 1);
    txn(0, 1'b1, 1'b0, 32'h0000_0100, '0, 1'b0, 1'b0);
    idle(0, 1);
    random_phase(0, 40);
    idle(0, 2);

    // LATENCY=1 instance: miss with writeback, back-to-back
    d1 = rand256();
    txn(1, 1'b1, 1'b0, 32'h0000_0020, rand256(), 1'b0, 1'b0);
    txn(1, 1'b0, 1'b1, 32'h0000_0020, d1, 1'b0, 1'b0);
    idle(1, 1);
    txn(1, 1'b1, 1'b0, 32'h0000_0020, '0, 1'b0, 1'b0);
    idle(1, 1);

    // read and write together: stored as a write, sticky error
    d2 = rand256();
    txn(1, 1'b1, 1'b1, 32'h0000_0060, d2, 1'b0, 1'b0);
    idle(1, 1);
    txn(1, 1'b1, 1'b0, 32'h0000_0160, '0, 1'b0, 1'b0);
    idle(1, 1);
    random_phase(1, 40);
    idle(1, 2);

    // write counter wrap from 0xFFFF
    force u_l1.write_cnt_q = 16'hFFFF;
    @(negedge clk);
    release u_l1.write_cnt_q;
    m_wc[1] = 32'hFFFF;
    @(negedge clk);
    check_eq(tg(1, "wc_preload"), 256'(wc[1]), 256'(m_wc[1]));
    txn(1, 1'b0, 1'b1, $urandom, rand256(), 1'b0, 1'b0);
    check_eq(tg(1, "wc_wrapped"), 256'(wc[1]), 256'(0));
    idle(1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
